// File: rtl/rtl_settings_pkg.sv
// Shared settings for the memory-side transaction path.
// Holds the default bus widths, the command type encodings and the
// transmitter state type used by trans_block and its testbench.
package rtl_settings_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 128;
    localparam int BURST_W = 11;

    localparam logic WR_TYPE = 1'b0;
    localparam logic RD_TYPE = 1'b1;

    typedef enum logic [1:0] {
        IDLE_S      = 2'd0,
        WRITE_S     = 2'd1,
        READ_WAIT_S = 2'd2,
        READ_S      = 2'd3
    } trans_state_t;

endpackage

// File: rtl/trans_data_gen.sv
// Write-data generator, shared with the compare stage so both sides build
// identical words.
// Each 32-bit lane carries the test pattern with the beat index XORed into
// its low 16 bits; the lane is replicated across the whole data word.
// Ports:
//   pattern_i  32-bit test pattern
//   beat_i     beat index within the burst (0 for the first beat)
//   data_o     DATA_W-bit write word
// DATA_W must be a multiple of 32.
module trans_data_gen #(
    parameter int DATA_W = 128,
    parameter int BEAT_W = 11
) (
    input  logic [31:0]       pattern_i,
    input  logic [BEAT_W-1:0] beat_i,
    output logic [DATA_W-1:0] data_o
);

    localparam int LANES = DATA_W / 32;

    logic [31:0] lane;

    always_comb begin
        lane   = pattern_i ^ {16'h0000, 16'(beat_i)};
        data_o = '0;
        for (int i = 0; i < LANES; i++) begin
            data_o[i*32 +: 32] = lane;
        end
    end

endmodule

// File: rtl/trans_block.sv
// Memory-side transmitter. Takes one command per handshake from the test
// control stage and turns it into a single Avalon-MM burst. Tracks read
// beats still in flight and reports process/busy status upstream.
//
// Handshake: a command is taken on any clock edge where trans_valid_i is
// high and trans_process_o is low; trans_process_o then stays high until the
// burst has been fully handed to the memory port, so a command presented
// while it is high simply waits.
//
// Ports:
//   clk_i, rst_n_i              clock, asynchronous active-low reset
//   start_test_i                pulse (idle only) latching burst_len_i / data_pattern_i
//   burst_len_i, data_pattern_i beats per burst (0 means 1), write pattern
//   trans_valid_i/type_i/addr_i command from the control stage
//   trans_process_o             command in execution
//   trans_busy_o                registered: processing or reads outstanding
//   mem_*                       Avalon-MM burst master
//   dbg_state_o                 current FSM state
//   dbg_outstanding_o           read beats currently in flight
module trans_block #(
    parameter int DATA_W          = rtl_settings_pkg::DATA_W,
    parameter int BURST_W         = rtl_settings_pkg::BURST_W,
    parameter int MAX_OUTSTANDING = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 start_test_i,
    input  logic [BURST_W-1:0]                   burst_len_i,
    input  logic [31:0]                          data_pattern_i,
    input  logic                                 trans_valid_i,
    input  logic                                 trans_type_i,
    input  logic [rtl_settings_pkg::ADDR_W-1:0]  trans_addr_i,
    output logic                                 trans_process_o,
    output logic                                 trans_busy_o,
    output logic [rtl_settings_pkg::ADDR_W-1:0]  mem_address_o,
    output logic                                 mem_read_o,
    output logic                                 mem_write_o,
    output logic [DATA_W-1:0]                    mem_writedata_o,
    output logic [DATA_W/8-1:0]                  mem_byteenable_o,
    output logic [BURST_W-1:0]                   mem_burstcount_o,
    input  logic                                 mem_waitrequest_i,
    input  logic                                 mem_readdatavalid_i,
    output rtl_settings_pkg::trans_state_t       dbg_state_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_outstanding_o
);

    import rtl_settings_pkg::*;

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    // Wide enough to hold outstanding + burst without wrapping.
    localparam int SUM_W = ((OUT_W > BURST_W) ? OUT_W : BURST_W) + 1;

    trans_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [BURST_W-1:0]  len_q;
    logic [31:0]         pattern_q;
    logic [BURST_W-1:0]  beat_q;
    logic [OUT_W-1:0]    out_q;
    logic                busy_q;

    logic                accept;
    logic                wr_beat;
    logic                wr_last;
    logic                rd_accept;
    logic                rd_room;
    logic [SUM_W-1:0]    rd_sum;
    logic [DATA_W-1:0]   gen_word;

    // Process is a pure decode of the state register, so it is low exactly
    // when the FSM can take a new command.
    assign trans_process_o  = (state_q != IDLE_S);
    assign accept           = trans_valid_i && !trans_process_o;
    assign wr_beat          = (state_q == WRITE_S) && !mem_waitrequest_i;
    assign wr_last          = wr_beat && (beat_q == (len_q - BURST_W'(1)));
    assign rd_accept        = (state_q == READ_S) && !mem_waitrequest_i;
    assign rd_sum           = SUM_W'(out_q) + SUM_W'(len_q);
    assign rd_room          = (rd_sum <= SUM_W'(MAX_OUTSTANDING));
    assign trans_busy_o     = busy_q;
    assign mem_byteenable_o = '1;
    assign dbg_state_o      = state_q;
    assign dbg_outstanding_o = out_q;

    trans_data_gen #(
        .DATA_W (DATA_W),
        .BEAT_W (BURST_W)
    ) u_data_gen (
        .pattern_i (pattern_q),
        .beat_i    (beat_q),
        .data_o    (gen_word)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE_S;
        end else begin
            state_q <= state_d;
        end
    end

    // Request outputs decode only registered state, so they cannot change
    // while waitrequest holds a beat on the bus.
    always_comb begin
        state_d          = state_q;
        mem_read_o       = 1'b0;
        mem_write_o      = 1'b0;
        mem_address_o    = '0;
        mem_burstcount_o = '0;
        mem_writedata_o  = '0;
        case (state_q)
            IDLE_S: begin
                if (accept) begin
                    state_d = (trans_type_i == RD_TYPE) ? READ_WAIT_S : WRITE_S;
                end
            end
            WRITE_S: begin
                mem_write_o      = 1'b1;
                mem_address_o    = addr_q;
                mem_burstcount_o = len_q;
                mem_writedata_o  = gen_word;
                if (wr_last) begin
                    state_d = IDLE_S;
                end
            end
            READ_WAIT_S: begin
                if (rd_room) begin
                    state_d = READ_S;
                end
            end
            READ_S: begin
                mem_read_o       = 1'b1;
                mem_address_o    = addr_q;
                mem_burstcount_o = len_q;
                if (rd_accept) begin
                    state_d = IDLE_S;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    // Test settings only change between commands.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            len_q     <= '0;
            pattern_q <= '0;
        end else if (start_test_i && (state_q == IDLE_S)) begin
            len_q     <= (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
            pattern_q <= data_pattern_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= trans_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            beat_q <= '0;
        end else if (wr_last) begin
            beat_q <= '0;
        end else if (wr_beat) begin
            beat_q <= beat_q + BURST_W'(1);
        end
    end

    // READ_WAIT_S guarantees room, so the add cannot exceed MAX_OUTSTANDING.
    // A stray readdatavalid with nothing outstanding leaves the count at 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_q <= '0;
        end else if (rd_accept) begin
            out_q <= OUT_W'(rd_sum - SUM_W'(mem_readdatavalid_i));
        end else if (mem_readdatavalid_i && (out_q != '0)) begin
            out_q <= out_q - OUT_W'(1);
        end
    end

    // Busy looks at the values held before this edge, so it trails process
    // and the outstanding count by one cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= trans_process_o || (out_q != '0);
        end
    end

    a_no_stray_rdv: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(mem_readdatavalid_i && !rd_accept && (out_q == '0)));

endmodule

// File: tb/tb_trans_block.sv
module tb_trans_block;

    import rtl_settings_pkg::*;

    localparam int DW   = 128;
    localparam int BW   = 11;
    localparam int MAXO = 16;
    localparam int OW   = $clog2(MAXO + 1);

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic              start_test_i = 1'b0;
    logic [BW-1:0]     burst_len_i = '0;
    logic [31:0]       data_pattern_i = '0;
    logic              trans_valid_i = 1'b0;
    logic              trans_type_i = 1'b0;
    logic [ADDR_W-1:0] trans_addr_i = '0;
    logic              trans_process_o;
    logic              trans_busy_o;
    logic [ADDR_W-1:0] mem_address_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [DW-1:0]     mem_writedata_o;
    logic [DW/8-1:0]   mem_byteenable_o;
    logic [BW-1:0]     mem_burstcount_o;
    logic              mem_waitrequest_i = 1'b0;
    logic              mem_readdatavalid_i = 1'b0;
    trans_state_t      dbg_state_o;
    logic [OW-1:0]     dbg_outstanding_o;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];

    trans_block #(
        .DATA_W          (DW),
        .BURST_W         (BW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i               (clk_i),
        .rst_n_i             (rst_n_i),
        .start_test_i        (start_test_i),
        .burst_len_i         (burst_len_i),
        .data_pattern_i      (data_pattern_i),
        .trans_valid_i       (trans_valid_i),
        .trans_type_i        (trans_type_i),
        .trans_addr_i        (trans_addr_i),
        .trans_process_o     (trans_process_o),
        .trans_busy_o        (trans_busy_o),
        .mem_address_o       (mem_address_o),
        .mem_read_o          (mem_read_o),
        .mem_write_o         (mem_write_o),
        .mem_writedata_o     (mem_writedata_o),
        .mem_byteenable_o    (mem_byteenable_o),
        .mem_burstcount_o    (mem_burstcount_o),
        .mem_waitrequest_i   (mem_waitrequest_i),
        .mem_readdatavalid_i (mem_readdatavalid_i),
        .dbg_state_o         (dbg_state_o),
        .dbg_outstanding_o   (dbg_outstanding_o)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Driver tasks
    task automatic load_test(input logic [BW-1:0] len, input logic [31:0] pat);
        start_test_i   = 1'b1;
        burst_len_i    = len;
        data_pattern_i = pat;
        tick;
        start_test_i   = 1'b0;
    endtask

    // Runs one write command; expected words come from exp_q, one per beat.
    // stall1/stall2 are waitrequest cycles inserted before beats 1 and 2.
    task automatic do_write(input logic [ADDR_W-1:0] addr, input int n_beats,
                            input int stall1, input int stall2);
        int st;
        trans_valid_i = 1'b1;
        trans_type_i  = WR_TYPE;
        trans_addr_i  = addr;
        checks++;
        if (trans_process_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_ready: process=%b want 0", trans_process_o);
        end
        tick;
        for (int k = 0; k < n_beats; k++) begin
            st = (k == 1) ? stall1 : ((k == 2) ? stall2 : 0);
            for (int s = 0; s <= st; s++) begin
                mem_waitrequest_i = (s < st);
                checks++;
                if (mem_write_o !== 1'b1 || mem_read_o !== 1'b0 || trans_process_o !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_req beat %0d: write=%b read=%b process=%b want 1 0 1",
                             k, mem_write_o, mem_read_o, trans_process_o);
                end
                checks++;
                if (mem_address_o !== addr || mem_burstcount_o !== BW'(n_beats)) begin
                    errors++;
                    $display("FAIL wr_addr beat %0d: addr=%h bc=%0d want %h %0d",
                             k, mem_address_o, mem_burstcount_o, addr, n_beats);
                end
                checks++;
                if (mem_writedata_o !== exp_q[0]) begin
                    errors++;
                    $display("FAIL wr_data beat %0d: got %h want %h", k, mem_writedata_o, exp_q[0]);
                end
                tick;
                trans_valid_i = 1'b0;
            end
            void'(exp_q.pop_front());
        end
        mem_waitrequest_i = 1'b0;
        checks++;
        if (mem_write_o !== 1'b0 || trans_process_o !== 1'b0 || dbg_state_o !== IDLE_S) begin
            errors++;
            $display("FAIL wr_end: write=%b process=%b state=%0d want 0 0 %0d",
                     mem_write_o, trans_process_o, dbg_state_o, IDLE_S);
        end
        checks++;
        if (trans_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL wr_busy_lag: busy=%b want 1", trans_busy_o);
        end
        tick;
        checks++;
        if (trans_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_busy_drop: busy=%b want 0", trans_busy_o);
        end
    endtask

    // Issues a read that has room; rv drives readdatavalid in the accept cycle.
    task automatic issue_read(input logic [ADDR_W-1:0] addr, input logic [BW-1:0] bc,
                              input logic rv);
        trans_valid_i = 1'b1;
        trans_type_i  = RD_TYPE;
        trans_addr_i  = addr;
        tick;
        trans_valid_i = 1'b0;
        checks++;
        if (dbg_state_o !== READ_WAIT_S || mem_read_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_wait: state=%0d read=%b want %0d 0", dbg_state_o, mem_read_o, READ_WAIT_S);
        end
        tick;
        checks++;
        if (mem_read_o !== 1'b1 || mem_write_o !== 1'b0 || mem_address_o !== addr ||
            mem_burstcount_o !== bc) begin
            errors++;
            $display("FAIL rd_req: read=%b write=%b addr=%h bc=%0d want 1 0 %h %0d",
                     mem_read_o, mem_write_o, mem_address_o, mem_burstcount_o, addr, bc);
        end
        mem_readdatavalid_i = rv;
        tick;
        mem_readdatavalid_i = 1'b0;
        checks++;
        if (mem_read_o !== 1'b0 || trans_process_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_done: read=%b process=%b want 0 0", mem_read_o, trans_process_o);
        end
    endtask

    task automatic return_beats(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            mem_readdatavalid_i = 1'b1;
            tick;
            checks++;
            if (int'(dbg_outstanding_o) !== start - i - 1) begin
                errors++;
                $display("FAIL rdv_count beat %0d: outstanding=%0d want %0d",
                         i, dbg_outstanding_o, start - i - 1);
            end
        end
        mem_readdatavalid_i = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset;
        tick;
        tick;
        checks++;
        if (mem_write_o !== 1'b0 || mem_read_o !== 1'b0 || trans_process_o !== 1'b0 ||
            trans_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: write=%b read=%b process=%b busy=%b want all 0",
                     mem_write_o, mem_read_o, trans_process_o, trans_busy_o);
        end
        checks++;
        if (mem_address_o !== '0 || mem_writedata_o !== '0 || mem_burstcount_o !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h data=%h bc=%0d want 0",
                     mem_address_o, mem_writedata_o, mem_burstcount_o);
        end
        checks++;
        if (mem_byteenable_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_be: be=%h want ffff", mem_byteenable_o);
        end
        checks++;
        if (dbg_state_o !== IDLE_S || dbg_outstanding_o !== '0) begin
            errors++;
            $display("FAIL reset_state: state=%0d outstanding=%0d want %0d 0",
                     dbg_state_o, dbg_outstanding_o, IDLE_S);
        end
        rst_n_i = 1'b1;
        tick;
    endtask

    task automatic test_write;
        load_test(11'd4, 32'hA5A5_0000);
        exp_q.push_back(128'hA5A50000_A5A50000_A5A50000_A5A50000);
        exp_q.push_back(128'hA5A50001_A5A50001_A5A50001_A5A50001);
        exp_q.push_back(128'hA5A50002_A5A50002_A5A50002_A5A50002);
        exp_q.push_back(128'hA5A50003_A5A50003_A5A50003_A5A50003);
        do_write(32'h0000_0100, 4, 0, 0);
    endtask

    task automatic test_write_stall;
        exp_q.push_back(128'hA5A50000_A5A50000_A5A50000_A5A50000);
        exp_q.push_back(128'hA5A50001_A5A50001_A5A50001_A5A50001);
        exp_q.push_back(128'hA5A50002_A5A50002_A5A50002_A5A50002);
        exp_q.push_back(128'hA5A50003_A5A50003_A5A50003_A5A50003);
        do_write(32'h0000_0100, 4, 3, 3);
    endtask

    // Length 0 runs as a single beat; start_test mid-command must be ignored.
    task automatic test_len_zero;
        load_test(11'd0, 32'hFFFF_FFFF);
        exp_q.push_back(128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
        do_write(32'h0000_0180, 1, 0, 0);
        trans_valid_i = 1'b1;
        trans_type_i  = WR_TYPE;
        trans_addr_i  = 32'h0000_01C0;
        tick;
        trans_valid_i = 1'b0;
        start_test_i  = 1'b1;
        burst_len_i   = 11'd7;
        checks++;
        if (mem_burstcount_o !== 11'd1 || mem_write_o !== 1'b1) begin
            errors++;
            $display("FAIL len0_bc: bc=%0d write=%b want 1 1", mem_burstcount_o, mem_write_o);
        end
        tick;
        start_test_i = 1'b0;
        checks++;
        if (mem_write_o !== 1'b0 || trans_process_o !== 1'b0) begin
            errors++;
            $display("FAIL len0_end: write=%b process=%b want 0 0", mem_write_o, trans_process_o);
        end
        exp_q.push_back(128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
        do_write(32'h0000_01C0, 1, 0, 0);
    endtask

    task automatic test_read;
        load_test(11'd8, 32'h0);
        issue_read(32'h0000_0200, 11'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dbg_outstanding_o !== OW'(8) || trans_busy_o !== 1'b1) begin
                errors++;
                $display("FAIL rd_outstanding: outstanding=%0d busy=%b want 8 1",
                         dbg_outstanding_o, trans_busy_o);
            end
            tick;
        end
        return_beats(8, 8);
        checks++;
        if (trans_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rd_busy_lag: busy=%b want 1", trans_busy_o);
        end
        tick;
        checks++;
        if (trans_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_busy_drop: busy=%b want 0", trans_busy_o);
        end
    endtask

    // With 16 beats in flight, the third 8-beat read needs outstanding <= 8
    // before it may leave READ_WAIT_S.
    task automatic test_back_to_back;
        issue_read(32'h0000_0300, 11'd8, 1'b0);
        issue_read(32'h0000_0340, 11'd8, 1'b0);
        checks++;
        if (dbg_outstanding_o !== OW'(16)) begin
            errors++;
            $display("FAIL b2b_full: outstanding=%0d want 16", dbg_outstanding_o);
        end
        trans_valid_i = 1'b1;
        trans_type_i  = RD_TYPE;
        trans_addr_i  = 32'h0000_0380;
        tick;
        trans_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (dbg_state_o !== READ_WAIT_S || mem_read_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_hold %0d: state=%0d read=%b want %0d 0",
                         i, dbg_state_o, mem_read_o, READ_WAIT_S);
            end
        end
        for (int i = 0; i < 8; i++) begin
            mem_readdatavalid_i = 1'b1;
            tick;
            checks++;
            if (dbg_state_o !== READ_WAIT_S || mem_read_o !== 1'b0 ||
                int'(dbg_outstanding_o) !== 15 - i) begin
                errors++;
                $display("FAIL b2b_drain %0d: state=%0d read=%b outstanding=%0d want %0d 0 %0d",
                         i, dbg_state_o, mem_read_o, dbg_outstanding_o, READ_WAIT_S, 15 - i);
            end
        end
        mem_readdatavalid_i = 1'b0;
        tick;
        checks++;
        if (mem_read_o !== 1'b1 || mem_address_o !== 32'h0000_0380) begin
            errors++;
            $display("FAIL b2b_issue: read=%b addr=%h want 1 00000380", mem_read_o, mem_address_o);
        end
        tick;
        checks++;
        if (dbg_outstanding_o !== OW'(16) || trans_process_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: outstanding=%0d process=%b want 16 0",
                     dbg_outstanding_o, trans_process_o);
        end
        return_beats(16, 16);
    endtask

    task automatic test_rd_overlap;
        load_test(11'd4, 32'h0);
        issue_read(32'h0000_0500, 11'd4, 1'b0);
        return_beats(4, 1);
        issue_read(32'h0000_0540, 11'd4, 1'b1);
        checks++;
        if (dbg_outstanding_o !== OW'(6)) begin
            errors++;
            $display("FAIL rd_overlap: outstanding=%0d want 6", dbg_outstanding_o);
        end
        return_beats(6, 6);
    endtask

    task automatic test_reset_mid_write;
        load_test(11'd4, 32'h1234_0000);
        trans_valid_i = 1'b1;
        trans_type_i  = WR_TYPE;
        trans_addr_i  = 32'h0000_0400;
        tick;
        trans_valid_i = 1'b0;
        tick;
        tick;
        checks++;
        if (mem_writedata_o !== 128'h12340002_12340002_12340002_12340002) begin
            errors++;
            $display("FAIL mid_beat2: data=%h want 12340002 x4", mem_writedata_o);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (mem_write_o !== 1'b0 || trans_process_o !== 1'b0 || trans_busy_o !== 1'b0 ||
            mem_address_o !== '0 || mem_writedata_o !== '0 || dbg_state_o !== IDLE_S) begin
            errors++;
            $display("FAIL mid_reset: write=%b process=%b busy=%b addr=%h state=%0d want 0 0 0 0 %0d",
                     mem_write_o, trans_process_o, trans_busy_o, mem_address_o, dbg_state_o, IDLE_S);
        end
        checks++;
        if (mem_byteenable_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL mid_reset_be: be=%h want ffff", mem_byteenable_o);
        end
        tick;
        rst_n_i = 1'b1;
        tick;
        load_test(11'd2, 32'h0F0F_F0F0);
        exp_q.push_back(128'h0F0FF0F0_0F0FF0F0_0F0FF0F0_0F0FF0F0);
        exp_q.push_back(128'h0F0FF0F1_0F0FF0F1_0F0FF0F1_0F0FF0F1);
        do_write(32'h0000_0440, 2, 0, 0);
    endtask

    initial begin
        test_reset;
        test_write;
        test_write_stall;
        test_len_zero;
        test_read;
        test_back_to_back;
        test_rd_overlap;
        test_reset_mid_write;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
